usb_cfg_cache: RTL and testbench
================================

Name: usb_cfg_cache

Overview:
- Buffers one 256-word packet read from the FX3 USB3 slave FIFO into an on-chip 256x32 RAM.
- Once the packet is complete, replays the first 24 words in order on q with a one-hot write strobe.
- The strobe loads the 24 per-channel configuration registers (8 channels x {carrier freq, 1.023 MHz code freq, code phase}) in the downstream register bank.
- Sits between the USB read FSM and the DA channel configuration bank.

Parameters:
- RD_LAT, 1: cycles between usb_rd_state==6 and the matching valid word on data.
- PKT_WORDS, 256: words per packet; RAM depth; must be a power of two.
- NUM_REGS, 24: number of configuration words replayed and width of wren_out.

Ports:
- clk, input, 1: single system clock; all logic rising-edge.
- rst, input, 1: asynchronous, active-high reset.
- data, input, 32: USB FIFO read data.
- usb_rd_state, input, 4: state of the USB read FSM; value 4'd6 = FIFO read in progress.
- usb3_flaga, input, 1: FX3 FLAGA, high when the FIFO holds data.
- q, output, 32: replayed configuration word.
- wren_out, output, NUM_REGS: one-hot strobe; bit i marks q as configuration word i.

Behaviour:
- Reset (async assert, sync release): wr_addr=0, rd_idx=0, readout idle, q=0, wren_out=0; RAM contents need not be cleared.
- Capture strobe: cap = (usb_rd_state==4'd6 AND usb3_flaga) delayed RD_LAT cycles through a shift register.
  - When cap=1, write data to RAM[wr_addr] and increment wr_addr.
  - wr_addr is log2(PKT_WORDS) bits and wraps 255->0.
  - Gaps in cap are allowed; the packet resumes at the held wr_addr.
- Packet done: a write with wr_addr==PKT_WORDS-1 pulses pkt_done for one cycle, and wr_addr wraps to 0.
- Readout FSM states:
  - IDLE: on pkt_done go to READ, rd_idx=0.
  - READ: each cycle present RAM address rd_idx and increment it; after address NUM_REGS-1 go to DRAIN.
  - DRAIN: one cycle for the final RAM output, then IDLE.
- RAM read latency is 1 cycle. q and wren_out are registered, so configuration word i appears on q with wren_out = 1<<i exactly 2 cycles after address i is presented.
- Consecutive strobes: wren_out=1, 2, 4, ... 1<<23 over 24 consecutive cycles, then 0.
- wren_out is 0 at all other times. q holds its last value when idle.
- pkt_done while not IDLE restarts the readout at rd_idx=0; the newest packet wins.
- A new packet may be written while readout runs. Writer and reader both start at address 0 and the reader advances every cycle, so it always stays ahead. Same-address read/write returns old data (read-before-write).
- Reset during capture or readout aborts both; the next packet starts at address 0.

Optional Feature:
- Macro CFG_TRAILER_CHECK_EN.
- Defined: when pkt_done occurs, readout starts only if the word written at address PKT_WORDS-1 equals 32'hFF0000AA. Otherwise the packet is dropped (wren_out stays 0) and a sticky status bit bad_pkt (extra output, cleared by rst) is set.
- Undefined: every completed packet is replayed; the bad_pkt port does not exist.

Decomposition:
- Package usb_cfg_pkg: USB_RD_STATE_READ=4'd6, PKT_WORDS, NUM_REGS, TRAILER=32'hFF0000AA, readout state enum {IDLE, READ, DRAIN}.
- Sub-module cfg_dpram: simple dual-port 256x32 RAM, one write port, one registered read port, same clock, read-before-write.
- Top holds the capture delay line, address counter, readout FSM and output registers.

Test Plan:
- Reset: assert rst mid-packet -> q=0 and wren_out=0 immediately; the following full packet is captured from address 0.
- Packet of words 0..255 (word 255 = 32'hFF0000AA when CFG_TRAILER_CHECK_EN is defined), usb3_flaga=1, usb_rd_state=6 -> 24 consecutive cycles with q=i and wren_out=1<<i for i=0..23, then wren_out=0.
- Second packet of words 255-i -> q=255, 254 ... 232 with the matching strobes; the earlier values are fully replaced.
- usb3_flaga=0 or usb_rd_state!=6 during data -> no RAM writes, no wren_out pulses.
- Packet split by a 10-cycle gap in usb_rd_state -> replay identical to the unbroken case.
- With CFG_TRAILER_CHECK_EN, last word 32'h000000FF -> no wren_out pulses, bad_pkt=1.

Source files
------------

// File: rtl/usb_cfg_pkg.sv
// Shared constants and types for the USB configuration packet cache.
// Trailer check feature is gated by CFG_TRAILER_CHECK_EN.
package usb_cfg_pkg;
  localparam logic [3:0] USB_RD_STATE_READ = 4'd6;
  localparam int PKT_WORDS = 256;
  localparam int NUM_REGS = 24;
  localparam int ADDR_W = $clog2(PKT_WORDS);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [31:0] TRAILER = 32'hFF00_00AA;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_e;
endpackage

// File: rtl/usb_cfg_cache_if.sv
// FIFO-side and register-bank-side signals of usb_cfg_cache.
// bad_pkt exists only when CFG_TRAILER_CHECK_EN is defined.
interface usb_cfg_cache_if;
  import usb_cfg_pkg::*;

  logic [31:0]         data;
  logic [3:0]          usb_rd_state;
  logic                usb3_flaga;
  logic [31:0]         q;
  logic [NUM_REGS-1:0] wren_out;
`ifdef CFG_TRAILER_CHECK_EN
  logic                bad_pkt;

  modport master (
    output data, usb_rd_state, usb3_flaga,
    input  q, wren_out, bad_pkt
  );
  modport slave (
    input  data, usb_rd_state, usb3_flaga,
    output q, wren_out, bad_pkt
  );
`else
  modport master (
    output data, usb_rd_state, usb3_flaga,
    input  q, wren_out
  );
  modport slave (
    input  data, usb_rd_state, usb3_flaga,
    output q, wren_out
  );
`endif
endinterface

// File: rtl/cfg_dpram.sv
// Simple dual-port packet RAM, registered read, read-before-write.
module cfg_dpram
  import usb_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);
  logic [31:0] r_mem [PKT_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/usb_cfg_cache.sv
// Captures one FX3 packet into RAM and replays its first NUM_REGS words.
// Define CFG_TRAILER_CHECK_EN to drop packets with a wrong trailer word.
module usb_cfg_cache
  import usb_cfg_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  usb_cfg_cache_if.slave bus
);
  logic [RD_LAT-1:0]   r_cap_sr;
  logic [ADDR_W-1:0]   r_wr_addr;
  rd_state_e           r_state;
  rd_state_e           w_state_nxt;
  logic [IDX_W-1:0]    r_rd_idx;
  logic [IDX_W-1:0]    w_rd_idx_nxt;
  logic [IDX_W-1:0]    r_rd_idx_d;
  logic                r_rd_vld;
  logic [31:0]         r_q;
  logic [NUM_REGS-1:0] r_wren;
  logic [31:0]         w_rdata;
  logic                w_cap_raw;
  logic                w_cap;
  logic                w_pkt_done;
  logic                w_start;
  logic                w_rd_en;

  assign w_cap_raw = (bus.usb_rd_state == USB_RD_STATE_READ)
                   && bus.usb3_flaga;
  assign w_cap = r_cap_sr[RD_LAT-1];
  assign w_pkt_done = w_cap
                   && (r_wr_addr == ADDR_W'(PKT_WORDS - 1));
  assign w_rd_en = (r_state == READ);

`ifdef CFG_TRAILER_CHECK_EN
  logic r_bad_pkt;

  // The trailer is the word being written on the done cycle.
  assign w_start = w_pkt_done && (bus.data == TRAILER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bad_pkt <= 1'b0;
    else if (w_pkt_done && !w_start) r_bad_pkt <= 1'b1;
  end

  assign bus.bad_pkt = r_bad_pkt;
`else
  assign w_start = w_pkt_done;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_sr  <= '0;
      r_wr_addr <= '0;
    end else begin
      r_cap_sr[0] <= w_cap_raw;
      for (int k = 1; k < RD_LAT; k++)
        r_cap_sr[k] <= r_cap_sr[k-1];
      if (w_cap) r_wr_addr <= r_wr_addr + ADDR_W'(1);
    end
  end

  cfg_dpram u_ram (
    .clk     (clk),
    .i_we    (w_cap),
    .i_waddr (r_wr_addr),
    .i_wdata (bus.data),
    .i_re    (w_rd_en),
    .i_raddr (ADDR_W'(r_rd_idx)),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rd_idx <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_idx <= w_rd_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_idx_nxt = r_rd_idx;
    unique case (r_state)
      IDLE: ;
      READ: begin
        w_rd_idx_nxt = r_rd_idx + IDX_W'(1);
        if (r_rd_idx == IDX_W'(NUM_REGS - 1))
          w_state_nxt = DRAIN;
      end
      DRAIN: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // A newer packet always restarts the replay.
    if (w_start) begin
      w_state_nxt  = READ;
      w_rd_idx_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld   <= 1'b0;
      r_rd_idx_d <= '0;
      r_q        <= '0;
      r_wren     <= '0;
    end else begin
      r_rd_vld   <= w_rd_en;
      r_rd_idx_d <= r_rd_idx;
      r_wren     <= r_rd_vld ? (NUM_REGS'(1) << r_rd_idx_d) : '0;
      if (r_rd_vld) r_q <= w_rdata;
    end
  end

  assign bus.q        = r_q;
  assign bus.wren_out = r_wren;
endmodule

// File: tb/tb_usb_cfg_cache.sv
// Directed self-checking bench for usb_cfg_cache.
// Define CFG_TRAILER_CHECK_EN to also exercise the trailer check.
module tb_usb_cfg_cache;
  import usb_cfg_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  usb_cfg_cache_if bus ();

  usb_cfg_cache dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] pkt_word(int kind, int i);
    logic [31:0] w;
    case (kind)
      0:       w = 32'(i);
      1:       w = 32'(255 - i);
      2:       w = 32'h1000_0000 + 32'(i * 3);
      3:       w = 32'hC0DE_0000 | 32'(i);
      default: w = 32'(i);
    endcase
    if (i == 255) w = (kind == 9) ? 32'h0000_00FF : TRAILER;
    return w;
  endfunction

  // FX3 model: the word requested in one cycle appears on data the next.
  task automatic send_packet(int kind, int nwords, int gap_at, int gap_len);
    int req = 0;
    int pend_idx = 0;
    bit pending = 0;
    int gap_left = gap_len;
    while (req < nwords || pending) begin
      @(negedge clk);
      bus.data = pending ? pkt_word(kind, pend_idx) : 32'hDEAD_BEEF;
      pending = 0;
      bus.usb3_flaga = 1'b1;
      if (req == gap_at && gap_left > 0) begin
        gap_left--;
        bus.usb_rd_state = 4'd0;
      end else if (req < nwords) begin
        bus.usb_rd_state = 4'd6;
        pending = 1;
        pend_idx = req;
        req++;
      end else begin
        bus.usb_rd_state = 4'd0;
      end
    end
  endtask

  task automatic check_replay(int kind, string name);
    logic [NUM_REGS-1:0] exp_w;
    logic [31:0] exp_q;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.usb_rd_state = 4'd0;
      n_chk++;
      if (bus.wren_out !== '0) begin
        n_fail++;
        $display("FAIL %s early strobe: wren_out=%h expected 0",
                 name, bus.wren_out);
      end
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      @(negedge clk);
      exp_w = NUM_REGS'(1) << i;
      exp_q = pkt_word(kind, i);
      n_chk++;
      if (bus.wren_out !== exp_w || bus.q !== exp_q) begin
        n_fail++;
        $display("FAIL %s word %0d: q=%h wren_out=%h expected q=%h wren_out=%h",
                 name, i, bus.q, bus.wren_out, exp_q, exp_w);
      end
    end
    @(negedge clk);
    exp_q = pkt_word(kind, NUM_REGS - 1);
    n_chk++;
    if (bus.wren_out !== '0 || bus.q !== exp_q) begin
      n_fail++;
      $display("FAIL %s after replay: q=%h wren_out=%h expected q=%h wren_out=0",
               name, bus.q, bus.wren_out, exp_q);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.data = '0;
    bus.usb_rd_state = 4'd0;
    bus.usb3_flaga = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.q !== 32'h0 || bus.wren_out !== '0) begin
      n_fail++;
      $display("FAIL reset_state: q=%h wren_out=%h expected 0/0",
               bus.q, bus.wren_out);
    end
`ifdef CFG_TRAILER_CHECK_EN
    n_chk++;
    if (bus.bad_pkt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bad_pkt: bad_pkt=%b expected 0", bus.bad_pkt);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_packet;
    send_packet(0, 256, -1, 0);
    check_replay(0, "ascending");
  endtask

  task automatic test_second_packet;
    send_packet(1, 256, -1, 0);
    check_replay(1, "descending");
  endtask

  task automatic test_no_capture;
    int bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      bus.data = 32'h5555_0000 + 32'(c);
      bus.usb_rd_state = 4'd6;
      bus.usb3_flaga = 1'b0;
      if (bus.wren_out !== '0) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL flaga_low: %0d strobe cycles expected 0", bad);
    end
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      bus.data = 32'h6666_0000 + 32'(c);
      bus.usb_rd_state = 4'd5;
      bus.usb3_flaga = 1'b1;
      if (bus.wren_out !== '0) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL state_not_read: %0d strobe cycles expected 0", bad);
    end
    send_packet(0, 256, -1, 0);
    check_replay(0, "after_idle_traffic");
  endtask

  task automatic test_gap;
    send_packet(2, 256, 50, 10);
    check_replay(2, "gap_packet");
  endtask

`ifdef CFG_TRAILER_CHECK_EN
  task automatic test_bad_trailer;
    int bad = 0;
    send_packet(9, 256, -1, 0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.wren_out !== '0) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bad_trailer_strobe: %0d strobe cycles expected 0", bad);
    end
    n_chk++;
    if (bus.bad_pkt !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_trailer_flag: bad_pkt=%b expected 1", bus.bad_pkt);
    end
  endtask
`endif

  task automatic test_reset_mid;
    send_packet(1, 100, -1, 0);
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.q !== 32'h0 || bus.wren_out !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: q=%h wren_out=%h expected 0/0",
               bus.q, bus.wren_out);
    end
`ifdef CFG_TRAILER_CHECK_EN
    n_chk++;
    if (bus.bad_pkt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_bad_pkt: bad_pkt=%b expected 0", bus.bad_pkt);
    end
`endif
    @(negedge clk);
    bus.usb_rd_state = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    send_packet(3, 256, -1, 0);
    check_replay(3, "after_reset");
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_packet();
    test_second_packet();
    test_no_capture();
    test_gap();
`ifdef CFG_TRAILER_CHECK_EN
    test_bad_trailer();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
